// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input registered mux family.
// Default width, channel-count ceiling and a select-width function.
package mux_pkg;

    localparam int unsigned MUX_DEFAULT_WIDTH = 16;
    localparam int unsigned MUX_MAX_N         = 16;

    // Select width for n channels, never narrower than one bit.
    function automatic int unsigned mux_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_arb_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr_i when MUX_N_ARB_RR_EN is defined,
// otherwise a lowest-index-wins priority encoder. Zero latency, no state.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = mux_clog2(N)
) (
    input  logic [N-1:0]    req_i,
`ifdef MUX_N_ARB_RR_EN
    input  logic [SELW-1:0] ptr_i,
`endif
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_vld_o
);

`ifdef MUX_N_ARB_RR_EN
    logic [SELW:0] cand;

    // Walk the channels starting at ptr_i, wrapping at N; first requester wins.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_i} + (SELW+1)'(i);
            if (cand >= (SELW+1)'(N)) begin
                cand = cand - (SELW+1)'(N);
            end
            if (!gnt_vld_o && req_i[cand[SELW-1:0]]) begin
                gnt_idx_o = cand[SELW-1:0];
                gnt_vld_o = 1'b1;
            end
        end
    end
`else
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_idx_o = SELW'(i);
                gnt_vld_o = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mux_n_arb.sv
// N-to-1 registered mux with forced select or arbitration (round-robin under MUX_N_ARB_RR_EN).
// One-cycle latency; single output register drains and reloads in the same cycle, stalls hold everything.
module mux_n_arb
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = mux_clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               force_en,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
        $error("mux_n_arb: N out of range");
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_src_q, out_src_d;

    logic             load_en;
    logic             force_hit;
    logic [SELW-1:0]  arb_idx;
    logic             arb_vld;
    logic [SELW-1:0]  grant_idx;
    logic             grant_vld;
    logic             xfer;
    logic [WIDTH-1:0] grant_word;

`ifdef MUX_N_ARB_RR_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
`endif

    rr_arbiter #(
        .N        (N)
    ) u_arb (
        .req_i    (in_valid),
`ifdef MUX_N_ARB_RR_EN
        .ptr_i    (ptr_q),
`endif
        .gnt_idx_o(arb_idx),
        .gnt_vld_o(arb_vld)
    );

    // A select beyond N-1 matches no channel, so it never grants.
    always_comb begin
        force_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                force_hit = in_valid[i];
            end
        end
    end

    assign load_en   = !out_valid_q || out_ready;
    assign grant_vld = force_en ? force_hit : arb_vld;
    assign grant_idx = force_en ? sel : arb_idx;
    assign xfer      = !rst && load_en && grant_vld;

    always_comb begin
        in_ready   = '0;
        grant_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = xfer;
                grant_word  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_word;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_N_ARB_RR_EN
    // Pointer moves past whichever channel was granted, forced or arbitrated.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef MUX_N_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_N_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb (N=4, WIDTH=16); reference model plus expected-word queue.
module tb_mux_n_arb;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0][W-1:0] ch;
    logic [N*W-1:0]     in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               force_en;
    logic [SW-1:0]      sel;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_src;

    int n_chk  = 0;
    int n_pass = 0;

    logic          m_vld;
    logic [SW-1:0] m_ptr;
    exp_t          sb[$];

    assign in_data = ch;

    always #5 clk = ~clk;

    mux_n_arb #(.WIDTH(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .force_en (force_en),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_grant(output logic gv, output logic [SW-1:0] gi);
        gv = 1'b0;
        gi = '0;
        if (force_en) begin
            gv = in_valid[sel];
            gi = sel;
        end else begin
`ifdef MUX_N_ARB_RR_EN
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % N;
                if (!gv && in_valid[idx]) begin
                    gv = 1'b1;
                    gi = SW'(idx);
                end
            end
`else
            for (int k = 0; k < N; k++) begin
                if (!gv && in_valid[k]) begin
                    gv = 1'b1;
                    gi = SW'(k);
                end
            end
`endif
        end
    endfunction

    // Check combinational and registered outputs against the model, then clock once.
    task automatic cycle();
        logic          gv;
        logic [SW-1:0] gi;
        logic          xf;
        logic [N-1:0]  erdy;
        exp_t          e;
        #1;
        model_grant(gv, gi);
        xf   = !rst && (!m_vld || out_ready) && gv;
        erdy = xf ? (4'b0001 << gi) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        if (m_vld && sb.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(sb[0].d));
            chk("out_src", 32'(out_src), 32'(sb[0].s));
            if (out_ready) void'(sb.pop_front());
        end
        if (xf) begin
            e.d = ch[gi];
            e.s = gi;
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0;
            m_ptr = '0;
            sb.delete();
        end else if (xf) begin
            m_vld = 1'b1;
            m_ptr = (gi == SW'(N - 1)) ? '0 : gi + 1'b1;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [SW-1:0] rr_exp [5];
`ifdef MUX_N_ARB_RR_EN
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        m_vld     = 1'b0;
        m_ptr     = '0;
        rst       = 1'b1;
        in_valid  = 4'b1111;
        force_en  = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        ch        = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};

        // Reset held with every channel requesting.
        cycle();
        cycle();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        rst = 1'b0;

        // Forced select of channel 2.
        force_en = 1'b1;
        sel      = 2'd2;
        ch[2]    = 16'hBEEF;
        #1;
        chk("force_rdy", 32'(in_ready), 32'h4);
        cycle();
        chk("force_data", 32'(out_data), 32'hBEEF);
        chk("force_src", 32'(out_src), 32'h2);
        chk("force_vld", 32'(out_valid), 32'h1);

        // Forced select of an idle channel: word drains, nothing reloads.
        sel      = 2'd1;
        in_valid = 4'b1101;
        cycle();
        chk("idle_vld", 32'(out_valid), 32'h0);
        cycle();

        // Arbitration from a freshly reset pointer.
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        force_en = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_seq", 32'(out_src), 32'(rr_exp[i]));
        end

        // Backpressure, with select inputs wiggled during the stall.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            force_en = i[0];
            sel      = SW'(i);
            cycle();
        end
        force_en  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        ch[3]     = 16'hC0DE;
        cycle();
        chk("reload_src", 32'(out_src), 32'h3);
        chk("reload_data", 32'(out_data), 32'hC0DE);

        // Reset in the middle of a stall discards the held word.
        in_valid = 4'b1111;
        cycle();
        out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(out_valid), 32'h0);
        chk("mid_rst_grant", 32'(in_ready), 32'h1);
        cycle();
        chk("mid_rst_src", 32'(out_src), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            force_en  = ($urandom_range(0, 3) == 0);
            sel       = SW'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) ch[c] = 16'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
